// File: rtl/pattern_stream_pkg.sv
// Shared types and helpers for the pattern stream controller.
package pattern_stream_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  // A zero or oversized length means a full word.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned w);
    return (len == 0 || len > w) ? w : len;
  endfunction

endpackage

// File: rtl/pattern_stream_shifter.sv
// Word load / shift-left register with a bit down-counter; presents the MSB and a last-bit flag.
module pattern_stream_shifter #(
  parameter int unsigned W  = 32,
  parameter int unsigned IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  word,
  input  logic [IW:0]   len,
  input  logic          shift,
  output logic          msb,
  output logic          last
);

  logic [W-1:0] sreg_q;
  logic [IW:0]  cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= word;
      cnt_q  <= len;
    end else if (shift) begin
      sreg_q <= {sreg_q[W-2:0], 1'b0};
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign msb  = sreg_q[W-1];
  assign last = (cnt_q == (IW+1)'(1));

endmodule

// File: rtl/pattern_stream_ctrl.sv
// Streams a parallel word MSB-first into a serial Mealy detector and
// summarises the detect pulses (count, first hit bit index).
module pattern_stream_ctrl
  import pattern_stream_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned CW = $clog2(W + 1),
  parameter int unsigned IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  word_i,
  input  logic [IW:0]   len_i,
  input  logic          clr_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          abort_i,
  output logic          det_in_o,
  output logic          det_clr_o,
  output logic          det_en_o,
  input  logic          detect_i,
  output logic          done_o,
  output logic          aborted_o,
  output logic          hit_o,
  output logic [CW-1:0] count_o,
  output logic [IW-1:0] first_idx_o
);

  state_e        state_q, state_d;
  logic          accept, in_shift, in_clear;
  logic          msb, last;
  logic [IW:0]   len_eff;
  logic          clr_q, seen_q, aborted_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] first_q, bit_idx_q;
  logic          hit_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] first_idx_q;

  assign accept   = (state_q == StIdle) && valid_i;
  assign in_shift = (state_q == StShift);
  assign in_clear = (state_q == StClear);
  assign len_eff  = (IW+1)'(eff_len(32'(len_i), W));

  pattern_stream_shifter #(
    .W  (W),
    .IW (IW)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .word  (word_i),
    .len   (len_eff),
    .shift (in_shift),
    .msb   (msb),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_i) state_d = StClear;
      StClear: state_d = abort_i ? StIdle : StShift;
      // Abort wins over the final-bit move to StDone.
      StShift: begin
        if (abort_i)   state_d = StIdle;
        else if (last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_o   = (state_q == StIdle);
    det_clr_o = in_clear && clr_q;
    det_en_o  = in_shift;
    det_in_o  = in_shift && msb;
    done_o    = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_q       <= 1'b0;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      first_q     <= '0;
      bit_idx_q   <= '0;
      aborted_q   <= 1'b0;
      hit_q       <= 1'b0;
      count_q     <= '0;
      first_idx_q <= '0;
    end else begin
      aborted_q <= abort_i && (in_clear || in_shift);
      if (accept) begin
        clr_q     <= clr_i;
        seen_q    <= 1'b0;
        cnt_q     <= '0;
        first_q   <= '0;
        bit_idx_q <= IW'(W - 1);
      end else if (in_shift) begin
        bit_idx_q <= bit_idx_q - 1'b1;
        if (detect_i) begin
          cnt_q <= cnt_q + 1'b1;
          if (!seen_q) begin
            seen_q  <= 1'b1;
            first_q <= bit_idx_q;
          end
        end
        // Results fold in the final bit's detect as the stream completes.
        if (last && !abort_i) begin
          hit_q       <= seen_q | detect_i;
          count_q     <= cnt_q + CW'(detect_i);
          first_idx_q <= seen_q ? first_q : (detect_i ? bit_idx_q : '0);
        end
      end
    end
  end

  assign aborted_o   = aborted_q;
  assign hit_o       = hit_q;
  assign count_o     = count_q;
  assign first_idx_o = first_idx_q;

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Directed bench for pattern_stream_ctrl driving an overlapping "101" Mealy detector model.
module tb_pattern_stream_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  word = '0;
  logic [IW:0]   len_in = '0;
  logic          clr_in = 1'b0;
  logic          valid = 1'b0;
  logic          abort = 1'b0;
  logic          ready, det_in, det_clr, det_en, detect, done, aborted, hit;
  logic [CW-1:0] count;
  logic [IW-1:0] first_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pattern_stream_ctrl #(
    .W  (W),
    .CW (CW),
    .IW (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .word_i      (word),
    .len_i       (len_in),
    .clr_i       (clr_in),
    .valid_i     (valid),
    .ready_o     (ready),
    .abort_i     (abort),
    .det_in_o    (det_in),
    .det_clr_o   (det_clr),
    .det_en_o    (det_en),
    .detect_i    (detect),
    .done_o      (done),
    .aborted_o   (aborted),
    .hit_o       (hit),
    .count_o     (count),
    .first_idx_o (first_idx)
  );

  // Detector model: 0 = nothing, 1 = saw "1", 2 = saw "10"; advances only on valid bits.
  logic [1:0] det_st = 2'd0;
  assign detect = det_en && det_in && (det_st == 2'd2);

  always @(posedge clk) begin
    if (det_clr) det_st <= 2'd0;
    else if (det_en) begin
      case (det_st)
        2'd0:    det_st <= det_in ? 2'd1 : 2'd0;
        2'd1:    det_st <= det_in ? 2'd1 : 2'd2;
        default: det_st <= det_in ? 2'd1 : 2'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done_o; cyc counts cycles with the accept cycle as 0.
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic run_stream(input logic [31:0] w, input logic [IW:0] len, input logic clr,
                            input int nbits, input int exp_cnt, input logic exp_hit,
                            input int exp_first);
    int cyc, en_n, clr_n;
    logic [31:0] cap;
    @(negedge clk);
    word = w; len_in = len; clr_in = clr; valid = 1'b1;
    check("ready_idle", ready, 1'b1);
    @(posedge clk); #1;
    valid = 1'b0;
    cyc = 1; en_n = 0; clr_n = 0; cap = '0;
    check("clear_ready", ready, 1'b0);
    check("clear_en", det_en, 1'b0);
    while (1) begin
      if (det_clr) clr_n++;
      if (det_en) begin
        cap = {cap[30:0], det_in};
        en_n++;
      end
      if (done || cyc >= 100) break;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", done, 1'b1);
    check("latency", cyc, nbits + 2);
    check("en_cycles", en_n, nbits);
    check("bits", cap, w >> (32 - nbits));
    check("clr_pulses", clr_n, {31'd0, clr});
    check("count", count, exp_cnt);
    check("hit", hit, exp_hit);
    check("first_idx", first_idx, exp_first);
    @(posedge clk); #1;
    check("done_pulse", done, 1'b0);
    check("ready_after", ready, 1'b1);
  endtask

  initial begin
    int cyc;
    #1 rst = 1'b0;
    #2;
    check("rst_ready", ready, 1'b1);
    check("rst_outs", {det_in, det_clr, det_en, done, aborted, hit}, 6'b0);
    check("rst_count", count, 0);
    check("rst_first", first_idx, 0);
    @(negedge clk); rst = 1'b1;

    // 1: full word via len=0, with clear.
    run_stream(32'hFDCAE398, 6'd0, 1'b1, 32, 3, 1'b1, 24);
    // 2: first 8 bits only.
    run_stream(32'hFDCAE398, 6'd8, 1'b1, 8, 1, 1'b1, 24);

    // 4: abort in the 5th SHIFT cycle; abort in IDLE is ignored.
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    check("idle_abort_ign", aborted, 1'b0);
    abort = 1'b0;
    @(negedge clk);
    word = 32'hFDCAE398; len_in = 6'd0; clr_in = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort_in_shift", det_en, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("aborted_pulse", aborted, 1'b1);
    check("abort_no_done", done, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_count", count, 1);
    check("abort_first", first_idx, 24);
    check("abort_hit", hit, 1'b1);
    @(posedge clk); #1;
    check("aborted_once", aborted, 1'b0);
    check("abort_no_done2", done, 1'b0);

    // 5: async reset mid-SHIFT with valid held.
    @(negedge clk);
    word = 32'hFDCAE398; len_in = 6'd0; clr_in = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("hold_not_ready", ready, 1'b0);
    check("hold_shifting", det_en, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_outs", {det_in, det_clr, det_en, done, aborted, hit}, 6'b0);
    check("mid_rst_count", count, 0);
    check("mid_rst_first", first_idx, 0);
    valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_stream(32'hFDCAE398, 6'd8, 1'b1, 8, 1, 1'b1, 24);

    // 3: all zeros replaces prior results.
    run_stream(32'h00000000, 6'd32, 1'b1, 32, 0, 1'b0, 0);

    // 6: back-to-back with valid held; second word without clear.
    @(negedge clk);
    word = 32'hFDCAE398; len_in = 6'd8; clr_in = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    word = 32'h40000000; len_in = 6'd3; clr_in = 1'b0;
    wait_done(1, cyc);
    check("b2b1_latency", cyc, 10);
    check("b2b1_count", count, 1);
    @(posedge clk); #1;
    check("b2b_ready", ready, 1'b1);
    @(posedge clk); #1;
    check("b2b_accepted", ready, 1'b0);
    check("b2b_noclr", det_clr, 1'b0);
    valid = 1'b0;
    wait_done(1, cyc);
    check("b2b2_latency", cyc, 5);
    check("b2b2_count", count, 1);
    check("b2b2_hit", hit, 1'b1);
    check("b2b2_first", first_idx, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_stream_ctrl.md
Name: pattern_stream_ctrl

Overview:
- Sequencer that feeds a serial Mealy pattern detector (1-bit `in_i` → `detect`) from parallel words.
- Accepts a word plus a bit length through a valid/ready handshake, then:
  - optionally clears the detector;
  - shifts the word out MSB-first, one bit per clock;
  - counts the detect pulses and records the bit index of the first hit.
- Sits between a host/register front end and one detector instance. It replaces ad-hoc bit-banging of the detector input.

Parameters:
- W, 32, data word width in bits; must be ≥ 2.
- CW, $clog2(W+1), width of the detect counter.
- IW, $clog2(W), width of bit-index fields.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- word_i  input  W  word to stream, transmitted MSB-first.
- len_i  input  IW+1  number of bits to stream; 0 or values above W mean W.
- clr_i  input  1  request a detector clear before streaming.
- valid_i  input  1  host request; qualifies word_i, len_i and clr_i.
- ready_o  output  1  controller can accept a request.
- abort_i  input  1  cancel the stream in progress.
- det_in_o  output  1  serial bit to the detector's in_i.
- det_clr_o  output  1  one-cycle synchronous clear to the detector.
- det_en_o  output  1  high while det_in_o carries a valid bit.
- detect_i  input  1  detector's Mealy detect output.
- done_o  output  1  one-cycle completion pulse.
- aborted_o  output  1  one-cycle abort acknowledge.
- hit_o  output  1  at least one detect occurred in the last completed stream.
- count_o  output  CW  number of detects in the last completed stream.
- first_idx_o  output  IW  word bit index (W-1..0) of the first detect.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - ready_o=1; det_in_o, det_clr_o, det_en_o, done_o, aborted_o, hit_o = 0.
  - count_o=0, first_idx_o=0.
- States: IDLE, CLEAR, SHIFT, DONE.
- IDLE:
  - ready_o=1.
  - On the edge where valid_i&ready_o: latch word_i, the effective length L and clr_i; go to CLEAR.
  - Internal count and first-hit flag zeroed. Outputs hit_o/count_o/first_idx_o keep their previous values until DONE.
- CLEAR (always exactly 1 cycle, for fixed latency):
  - det_clr_o = latched clr flag.
  - det_en_o=0, ready_o=0.
  - Next state: SHIFT.
- SHIFT (L cycles, k = 0..L-1):
  - det_in_o = word[W-1-k]; det_en_o=1; ready_o=0.
  - detect_i is sampled at the same rising edge that ends the bit's cycle (Mealy: detect belongs to the current bit).
  - On sampled detect_i=1: count += 1. If it is the first hit, first_idx := W-1-k.
  - After bit k=L-1 is sampled, go to DONE.
  - Bits word[W-1-L..0] are never driven.
- DONE (1 cycle):
  - done_o=1.
  - hit_o, count_o, first_idx_o update at entry to DONE and hold until the next DONE or reset.
  - ready_o=0. Next state: IDLE.
- Latency: accept edge → done_o high L+2 cycles later. Minimum request-to-request spacing is L+3 cycles.
- detect_i is ignored in IDLE, CLEAR and DONE.
- Count cannot overflow: CW covers W.
- No hit: first_idx_o=0, hit_o=0.
- abort_i:
  - In CLEAR or SHIFT: next edge → IDLE, aborted_o=1 for one cycle, done_o not asserted, result outputs unchanged.
  - Abort takes priority over the final-bit transition to DONE.
  - Ignored in IDLE and DONE.
- valid_i while ready_o=0 is ignored; the host must hold the request.
- Reset mid-stream: immediate return to IDLE with reset values. The detector is not cleared automatically; the host sets clr_i on the next request.

Decomposition:
- Package pattern_stream_pkg:
  - state encoding localparams (IDLE=2'd0, CLEAR=2'd1, SHIFT=2'd2, DONE=2'd3);
  - a function for the effective length (0 or >W maps to W).
- One sub-module, pattern_stream_shifter:
  - W-bit load/shift-left register with an IW+1-bit down-counter;
  - outputs the MSB and a last-bit flag.
- The FSM, detect counter and first-index capture stay in the top.

Test Plan:
The bench connects a behavioural overlapping "101" Mealy detector model.
1. word=32'hFDCAE398, len=0, clr=1 → det_clr_o pulses once; 32 det_en_o cycles with bits 1,1,1,1,1,1,0,1,…; done_o 34 cycles after accept; count_o=3, hit_o=1, first_idx_o=24.
2. word=32'hFDCAE398, len=8, clr=1 → only bits 31..24 streamed; count_o=1, first_idx_o=24; done_o 10 cycles after accept.
3. word=32'h00000000, len=32 → count_o=0, hit_o=0, first_idx_o=0; previous results replaced on done_o.
4. Abort asserted on the 5th SHIFT cycle of scenario 1 → aborted_o pulse, no done_o, count_o/first_idx_o still show the prior values, ready_o=1 next cycle.
5. rst driven low mid-SHIFT, asynchronously between edges → all outputs immediately at reset values. A new request after release completes normally. valid_i held during SHIFT is not accepted until IDLE.
6. Back-to-back requests with valid_i held high → second accept exactly 1 cycle after done_o; clr=0 on the second word leaves det_clr_o low.
